// File: rtl/col_line_buffer_if.sv
// Pixel-stream handshake and row-triple output bundle for col_line_buffer.
// master drives raster pixels and consumes triples; slave is the line buffer.
interface col_line_buffer_if #(
  parameter int PIX_W      = 12,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic             in_valid;
  logic             in_sof;
  logic             in_ready;
  logic [PIX_W-1:0] pixel_in;
  logic             out_valid;
  logic [PIX_W-1:0] row0_pixel;
  logic [PIX_W-1:0] row1_pixel;
  logic [PIX_W-1:0] row2_pixel;
  logic [CW-1:0]    out_col;
  logic [RW-1:0]    out_row;
  logic             out_eof;

  modport master (
    output in_valid, in_sof, pixel_in,
    input  in_ready, out_valid, row0_pixel, row1_pixel, row2_pixel,
           out_col, out_row, out_eof
  );

  modport slave (
    input  in_valid, in_sof, pixel_in,
    output in_ready, out_valid, row0_pixel, row1_pixel, row2_pixel,
           out_col, out_row, out_eof
  );
endinterface

// File: rtl/col_line_buffer.sv
// 3-row window generator: two line memories turn a raster pixel stream into column triples.
// Define COL_LB_BORDER_REPLICATE_EN to also emit replicated top and bottom border rows.
module col_line_buffer #(
  parameter int PIX_W      = 12,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic               clk,
  input  logic               reset_n,
  col_line_buffer_if.slave   bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW1     = RW'(1);
  localparam logic [RW-1:0] ROW2     = RW'(2);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

  state_t           state;
  logic [PIX_W-1:0] lb_old [IMG_WIDTH];
  logic [PIX_W-1:0] lb_new [IMG_WIDTH];
  logic [CW-1:0]    in_col, cur_col, nxt_col;
  logic [RW-1:0]    in_row, cur_row, nxt_row;
  logic             in_ready, take, emit, last_col, last_pix;

`ifdef COL_LB_BORDER_REPLICATE_EN
  localparam logic [RW-1:0] FIRST_OUT_ROW = ROW1;
  logic [CW-1:0] flush_col;
`else
  localparam logic [RW-1:0] FIRST_OUT_ROW = ROW2;
  assign in_ready = 1'b1;
`endif

  assign bus.in_ready = in_ready;

  // An sof pixel is always position (0,0), whatever the counters held.
  always_comb begin
    cur_col  = bus.in_sof ? '0 : in_col;
    cur_row  = bus.in_sof ? '0 : in_row;
    last_col = (cur_col == LAST_COL);
    last_pix = last_col && (cur_row == LAST_ROW);
    nxt_col  = last_col ? '0 : cur_col + 1'b1;
    nxt_row  = last_col ? cur_row + 1'b1 : cur_row;
    take     = bus.in_valid && in_ready && ((state != IDLE) || bus.in_sof);
    emit     = take && (cur_row >= FIRST_OUT_ROW);
  end

  always_ff @(posedge clk) begin
    if (take) begin
      lb_old[cur_col] <= lb_new[cur_col];
      lb_new[cur_col] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      in_col         <= '0;
      in_row         <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_eof    <= 1'b0;
      bus.row0_pixel <= '0;
      bus.row1_pixel <= '0;
      bus.row2_pixel <= '0;
      bus.out_col    <= '0;
      bus.out_row    <= '0;
`ifdef COL_LB_BORDER_REPLICATE_EN
      in_ready       <= 1'b1;
      flush_col      <= '0;
`endif
    end else begin
      bus.out_valid <= 1'b0;
      bus.out_eof   <= 1'b0;
`ifdef COL_LB_BORDER_REPLICATE_EN
      // Bottom border: replay the last two rows with the last row standing in below.
      if (state == FLUSH) begin
        bus.out_valid  <= 1'b1;
        bus.row0_pixel <= lb_old[flush_col];
        bus.row1_pixel <= lb_new[flush_col];
        bus.row2_pixel <= lb_new[flush_col];
        bus.out_col    <= flush_col;
        bus.out_row    <= LAST_ROW;
        flush_col      <= flush_col + 1'b1;
        if (flush_col == LAST_COL) begin
          bus.out_eof <= 1'b1;
          in_ready    <= 1'b1;
          state       <= IDLE;
        end
      end else
`endif
      if (take) begin
        in_col <= nxt_col;
        in_row <= nxt_row;
        if (emit) begin
          // Row 1 input only emits in border mode, where row 0 doubles as the row above.
          bus.out_valid  <= 1'b1;
          bus.row0_pixel <= (cur_row == ROW1) ? lb_new[cur_col] : lb_old[cur_col];
          bus.row1_pixel <= lb_new[cur_col];
          bus.row2_pixel <= bus.pixel_in;
          bus.out_col    <= cur_col;
          bus.out_row    <= cur_row - ROW1;
        end
        if (last_pix) begin
`ifdef COL_LB_BORDER_REPLICATE_EN
          state     <= FLUSH;
          in_ready  <= 1'b0;
          flush_col <= '0;
`else
          state       <= IDLE;
          bus.out_eof <= 1'b1;
`endif
        end else begin
          state <= (nxt_row >= ROW2) ? STREAM : FILL;
        end
      end
    end
  end
endmodule

// File: doc/col_line_buffer.md
Name: col_line_buffer

Overview:
- Streaming 3-row window generator that sits directly upstream of the column-derivative kernel (Ix) and the row-derivative stage.
- Accepts one raster-order pixel per cycle and stores the two previous image rows in internal line memories.
- Emits a column-aligned triple every cycle: row above, centre row, row below. row0_pixel and row2_pixel feed the Ix kernel directly; row1_pixel serves the centre-row consumers.

Parameters:
PIX_W, 12, pixel width in bits (unsigned)
IMG_WIDTH, 640, pixels per row (>= 4)
IMG_HEIGHT, 480, rows per frame (>= 3)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  pixel_in valid this cycle
in_sof  in  1  start of frame; qualified by in_valid; marks pixel (row 0, col 0)
in_ready  out  1  block accepts input; low only during FLUSH
pixel_in  in  PIX_W  input pixel, raster order
out_valid  out  1  output triple valid
row0_pixel  out  PIX_W  pixel at (c-1, col)
row1_pixel  out  PIX_W  pixel at (c, col), centre row
row2_pixel  out  PIX_W  pixel at (c+1, col)
out_col  out  $clog2(IMG_WIDTH)  column index of the triple
out_row  out  $clog2(IMG_HEIGHT)  centre-row index c
out_eof  out  1  high with the last triple of the frame

Behaviour:
- Clock and reset: one clock domain, clk. reset_n is asynchronous and active-low.
- Reset values: all outputs 0 except in_ready=1; counters 0; FSM in IDLE. Line-memory contents are don't-care.
- Input acceptance: a pixel is accepted when in_valid && in_ready. There is no output backpressure; consumers must take every out_valid cycle.
- Storage: two line memories, lb_old (row r-2) and lb_new (row r-1), each IMG_WIDTH deep and addressed by in_col. On every accepted pixel, in the same cycle:
  - lb_old[col] is read, and lb_new[col] is read and written into lb_old[col];
  - pixel_in is written into lb_new[col].
- Output latency: 1 cycle after acceptance. row0/row1/row2 = registered old lb_old, old lb_new, and pixel_in. The row triple changes only together with out_valid.
- Counters: in_col counts 0..IMG_WIDTH-1 and wraps to 0 with in_row+1. out_col and out_row are registered copies of in_col and in_row-1.
- FSM states:
  - IDLE: accepted pixels without in_sof are dropped. An accepted in_sof pixel sets in_col=0, in_row=0 and moves to FILL; the pixel itself is stored.
  - FILL: rows 0 and 1 are written to memory, out_valid=0. Entering row 2 moves to STREAM.
  - STREAM: out_valid=1 for each accepted pixel. The last pixel (row IMG_HEIGHT-1, col IMG_WIDTH-1) produces out_eof=1 and moves to IDLE, or to FLUSH when the optional feature is compiled in.
  - FLUSH: only with the optional feature; see that section.
- Without the optional feature, output covers centre rows 1..IMG_HEIGHT-2 only: (IMG_HEIGHT-2)*IMG_WIDTH triples per frame.
- Boundary cases:
  - in_sof accepted in FILL or STREAM aborts the current frame: counters restart at (0,0), state goes to FILL, and no out_eof is produced for the aborted frame.
  - in_valid low simply stalls the counters; outputs hold their values with out_valid=0.
  - Async reset mid-frame returns to IDLE immediately; the next frame requires in_sof.
- Arithmetic: none. Pixels are passed through unsigned and unmodified.

Optional Feature:
- Macro: COL_LB_BORDER_REPLICATE_EN.
- Defined: the block emits all IMG_HEIGHT centre rows, with edge rows replicated.
  - Top border: during row 1 input, out_valid=1 with out_row=0, row0=row1=lb_new (row 0) and row2=pixel_in.
  - Bottom border: after the last input pixel the FSM enters FLUSH. in_ready=0 for IMG_WIDTH cycles while the block reads the memories by an internal column counter and emits out_row=IMG_HEIGHT-1 with row0=lb_old, row1=row2=lb_new. out_eof is asserted on the final flush cycle, then the FSM returns to IDLE.
  - in_sof cannot be accepted during FLUSH because in_ready=0.
  - Total IMG_HEIGHT*IMG_WIDTH triples per frame.
- Undefined: FLUSH state and top-border output are absent, in_ready is tied to 1, and behaviour is as in Behaviour.

Test Plan:
- Reset: W=8, H=6. Hold reset_n=0 with random inputs -> all outputs 0, in_ready=1; after release, out_valid stays 0 until a frame arrives.
- Full frame: pixel value = row*16+col, continuous valid -> first out_valid exactly 1 cycle after pixel (2,0) is accepted, with row0=0x00, row1=0x10, row2=0x20. 32 triples in total; out_eof on triple (4,7) with row2=0x57.
- Gaps: the same frame with in_valid randomly low 50% of cycles -> identical triple sequence, with out_valid only on cycles following acceptance.
- Mid-frame restart: in_sof at input (3,2) -> no out_eof for the aborted frame. The new frame's first triple has out_row=1, and its data comes from new-frame rows only.
- Headless data: pixels without in_sof while IDLE -> dropped and no out_valid; the next in_sof frame is correct.
- COL_LB_BORDER_REPLICATE_EN: same full frame -> 48 triples. Triple (0,3) is 0x03/0x03/0x13; FLUSH keeps in_ready=0 for 8 cycles; triple (5,7) is 0x47/0x57/0x57 with out_eof=1.
